// File: rtl/disp_filter_pkg.sv
// Shared types and helpers for the disparity filtering path.
//   conf_w / disp_w : widths of block confidence and disparity
//   popcount        : set-bit count of the low `width` bits of a vector
//   decim_pix_t     : one decimated output pixel with raster flags
package disp_filter_pkg;

    localparam int conf_w         = 8;
    localparam int disp_w         = 8;
    localparam int popcount_max_w = 32;
    localparam int fill_max_w     = 8;

    typedef struct packed {
        logic [disp_w-1:0]     disp;
        logic [conf_w-1:0]     conf;
        logic [fill_max_w-1:0] fill;
        logic                  sol;
        logic                  eol;
        logic                  eof;
    } decim_pix_t;

    // Callers zero-extend their vector to popcount_max_w and pass the real
    // width, so one function serves every mask width up to 32 bits.
    function automatic logic [fill_max_w-1:0] popcount(
        input logic [popcount_max_w-1:0] bits,
        input int                        width
    );
        logic [fill_max_w-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < popcount_max_w; i++) begin
            if (i < width) cnt = cnt + fill_max_w'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/raster_pos_counter.sv
// Nested column / row / strip position counter for decimated raster output.
//   clk, reset : clock, synchronous active-high reset
//   en         : advance one pixel position
//   sol/eol    : current position is first / last column of a row
//   eof        : current position is the last pixel of the frame
module raster_pos_counter #(
    parameter int cols   = 120,
    parameter int rows   = 8,
    parameter int strips = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sol,
    output logic eol,
    output logic eof
);

    localparam int col_w   = (cols   > 1) ? $clog2(cols)   : 1;
    localparam int row_w   = (rows   > 1) ? $clog2(rows)   : 1;
    localparam int strip_w = (strips > 1) ? $clog2(strips) : 1;

    localparam logic [col_w-1:0]   col_last   = col_w'(cols - 1);
    localparam logic [row_w-1:0]   row_last   = row_w'(rows - 1);
    localparam logic [strip_w-1:0] strip_last = strip_w'(strips - 1);

    logic [col_w-1:0]   col;
    logic [row_w-1:0]   row;
    logic [strip_w-1:0] strip;
    logic               last_row;
    logic               last_strip;

    assign sol        = (col == '0);
    assign eol        = (col == col_last);
    assign last_row   = (row == row_last);
    assign last_strip = (strip == strip_last);
    assign eof        = eol && last_row && last_strip;

    always_ff @(posedge clk) begin
        if (reset) begin
            col   <= '0;
            row   <= '0;
            strip <= '0;
        end else if (en) begin
            if (eol) begin
                col <= '0;
                if (last_row) begin
                    row   <= '0;
                    strip <= last_strip ? '0 : strip + strip_w'(1);
                end else begin
                    row <= row + row_w'(1);
                end
            end else begin
                col <= col + col_w'(1);
            end
        end
    end

endmodule

// File: rtl/xor_stream_decimator.sv
// Decimates the XOR mask stream into one disparity pixel per tile.
// Each decimate_factor x decimate_factor tile arrives as decimate_factor
// beats of decimate_factor mask bits; the set bits are counted and the
// block disparity is kept only when both fill and confidence clear their
// thresholds.
//   clk, reset          : clock, synchronous active-high reset
//   pix_stream_data     : mask bits of the current beat
//   conf_in / disp_in   : block confidence / disparity for the beat
//   pix_stream_valid    : beat valid (no backpressure)
//   fill_thresh         : minimum set-bit count for a valid pixel
//   conf_thresh         : minimum confidence for a valid pixel
//   out_valid           : one-cycle pulse per tile, 1 cycle after last beat
//   out_disp/conf/fill  : gated disparity, raw confidence, tile fill
//   out_sol/eol/eof     : raster flags, qualified by out_valid
module xor_stream_decimator
    import disp_filter_pkg::*;
#(
    parameter int decimate_factor  = 2,
    parameter int frame_w          = 240,
    parameter int strip_h          = 16,
    parameter int strips_per_frame = 15,
    parameter int fill_w           = $clog2(decimate_factor*decimate_factor + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [decimate_factor-1:0] pix_stream_data,
    input  logic [7:0]                 conf_in,
    input  logic [7:0]                 disp_in,
    input  logic                       pix_stream_valid,
    input  logic [fill_w-1:0]          fill_thresh,
    input  logic [7:0]                 conf_thresh,
    output logic                       out_valid,
    output logic [7:0]                 out_disp,
    output logic [7:0]                 out_conf,
    output logic [fill_w-1:0]          out_fill,
    output logic                       out_sol,
    output logic                       out_eol,
    output logic                       out_eof
);

    localparam int beat_w = (decimate_factor > 1) ? $clog2(decimate_factor) : 1;
    localparam logic [beat_w-1:0] beat_last_idx = beat_w'(decimate_factor - 1);

    logic [beat_w-1:0] beat_p0;
    logic [fill_w-1:0] acc_p0;
    logic [fill_w-1:0] beat_pop;
    logic [fill_w-1:0] tile_sum;
    logic              last_beat;
    logic              tile_done;
    logic              pix_pass;
    logic              pos_sol;
    logic              pos_eol;
    logic              pos_eof;

    logic              vld_p1;
    logic [disp_w-1:0] disp_p1;
    logic [conf_w-1:0] conf_p1;
    logic [fill_w-1:0] fill_p1;
    logic              sol_p1;
    logic              eol_p1;
    logic              eof_p1;

    always_comb begin
        beat_pop  = fill_w'(popcount(popcount_max_w'(pix_stream_data), decimate_factor));
        tile_sum  = acc_p0 + beat_pop;
        last_beat = (beat_p0 == beat_last_idx);
        tile_done = pix_stream_valid && last_beat;
        pix_pass  = (tile_sum >= fill_thresh) && (conf_in >= conf_thresh);
    end

    // Position reflects the pixel being emitted this tile; it advances
    // after the flags have been captured.
    raster_pos_counter #(
        .cols   (frame_w / decimate_factor),
        .rows   (strip_h / decimate_factor),
        .strips (strips_per_frame)
    ) u_pos (
        .clk   (clk),
        .reset (reset),
        .en    (tile_done),
        .sol   (pos_sol),
        .eol   (pos_eol),
        .eof   (pos_eof)
    );

    // ---- stage p0 -> p1: tile accumulation and output register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_p0 <= '0;
            acc_p0  <= '0;
            vld_p1  <= 1'b0;
            disp_p1 <= '0;
            conf_p1 <= '0;
            fill_p1 <= '0;
            sol_p1  <= 1'b0;
            eol_p1  <= 1'b0;
            eof_p1  <= 1'b0;
        end else begin
            vld_p1 <= tile_done;
            // Flags are cleared on non-output cycles so they never appear
            // without out_valid.
            sol_p1 <= tile_done && pos_sol;
            eol_p1 <= tile_done && pos_eol;
            eof_p1 <= tile_done && pos_eof;
            if (pix_stream_valid) begin
                if (last_beat) begin
                    beat_p0 <= '0;
                    acc_p0  <= '0;
                    disp_p1 <= pix_pass ? disp_in : '0;
                    conf_p1 <= conf_in;
                    fill_p1 <= tile_sum;
                end else begin
                    beat_p0 <= beat_p0 + beat_w'(1);
                    acc_p0  <= tile_sum;
                end
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_disp  = disp_p1;
    assign out_conf  = conf_p1;
    assign out_fill  = fill_p1;
    assign out_sol   = sol_p1;
    assign out_eol   = eol_p1;
    assign out_eof   = eof_p1;

endmodule
